divisor_de_reloj_prog: RTL



---
 rtl/divisor_de_reloj_prog_pkg.sv | 21 ++
 rtl/divisor_de_reloj_prog_etapa.sv | 33 +++
 rtl/divisor_de_reloj_prog.sv | 114 +++++++++++
 3 files changed

// File: rtl/divisor_de_reloj_prog_pkg.sv
// Shared clocking constants and helpers for the programmable clock divider
// and the phy_rx/phy_tx blocks that sit below it.
package divisor_de_reloj_prog_pkg;

  localparam int unsigned STAGES_DEF = 5;
  localparam int unsigned SEL_W_DEF  = 3;
  localparam int unsigned CNT_MAX    = (1 << STAGES_DEF) - 1;

  typedef enum logic [1:0] {
    CTRL_FREEZE,
    CTRL_COUNT,
    CTRL_ALIGN
  } ctrl_e;

  // Requested stage indices beyond the chain fall back to the slowest stage.
  function automatic int unsigned clamp_sel(input int unsigned sel,
                                            input int unsigned stages);
    return (sel < stages) ? sel : stages - 1;
  endfunction

endpackage

// File: rtl/divisor_de_reloj_prog_etapa.sv
// One divide-by-2 T-stage: toggles when enabled, synchronous clear,
// asynchronous active-low reset.
module etapa_toggle (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic tog_i,
  output logic q_o
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 1'b0;
    end else if (tog_i) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/divisor_de_reloj_prog.sv
// Programmable synchronous binary clock divider with freeze, phase realign,
// per-stage rising-edge strobes and a rate select applied only at wrap.
module divisor_de_reloj_prog
  import divisor_de_reloj_prog_pkg::*;
#(
  parameter int unsigned STAGES = STAGES_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              ENABLE,
  input  logic              ALIGN,
  input  logic [SEL_W-1:0]  SEL,
  output logic [STAGES-1:0] DIV,
  output logic [STAGES-1:0] STB,
  output logic              CLK_SEL,
  output logic              STB_SEL,
  output logic [SEL_W-1:0]  SEL_ACT,
  output logic              WRAP
);

  ctrl_e             ctrl;
  logic [STAGES-1:0] cnt;
  logic [STAGES:0]   carry;
  logic [STAGES-1:0] tog;
  logic              align_clr;
  logic [SEL_W-1:0]  sel_clamped;

  logic [STAGES-1:0] stb_d,  stb_q;
  logic              wrap_d, wrap_q;
  logic [SEL_W-1:0]  sel_d,  sel_q;

  always_comb begin
    ctrl = CTRL_FREEZE;
    if (ALIGN) begin
      ctrl = CTRL_ALIGN;
    end else if (ENABLE) begin
      ctrl = CTRL_COUNT;
    end
  end

  // carry[i] is high when every bit below i is set; carry[STAGES] marks all-ones.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int unsigned i = 0; i < STAGES; i++) begin
      carry[i+1] = carry[i] & cnt[i];
    end
  end

  assign align_clr = (ctrl == CTRL_ALIGN);
  assign tog       = (ctrl == CTRL_COUNT) ? carry[STAGES-1:0] : '0;

  for (genvar g = 0; g < STAGES; g++) begin : g_etapa
    etapa_toggle u_etapa (
      .clk   (CLK),
      .rst_n (RESET_L),
      .clr_i (align_clr),
      .tog_i (tog[g]),
      .q_o   (cnt[g])
    );
  end

  assign sel_clamped = SEL_W'(clamp_sel(32'(SEL), STAGES));

  always_comb begin
    stb_d  = '0;
    wrap_d = 1'b0;
    sel_d  = sel_q;
    case (ctrl)
      CTRL_COUNT: begin
        stb_d  = carry[STAGES-1:0] & ~cnt;
        wrap_d = carry[STAGES];
        if (carry[STAGES]) begin
          sel_d = sel_clamped;
        end
      end
      CTRL_ALIGN: begin
        sel_d = sel_clamped;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      stb_q  <= '0;
      wrap_q <= 1'b0;
      sel_q  <= '0;
    end else begin
      stb_q  <= stb_d;
      wrap_q <= wrap_d;
      sel_q  <= sel_d;
    end
  end

  always_comb begin
    CLK_SEL = 1'b0;
    STB_SEL = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        CLK_SEL = cnt[i];
        STB_SEL = stb_q[i];
      end
    end
  end

  assign DIV     = cnt;
  assign STB     = stb_q;
  assign WRAP    = wrap_q;
  assign SEL_ACT = sel_q;

endmodule
